// File: rtl/seg7_display.sv
// Eight-digit, common-anode seven-segment display driver.
// It shows a 16-bit word either as 4 hex digits or as up to 5 unsigned decimal digits.
// A sequential double-dabble converter produces the decimal digits.
// Hex and decimal output both come from the same shadow copy, so the two views always agree.
module seg7_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        dec_mode,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    localparam logic [15:0] PreMax = 16'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] acc_q, acc_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pre_q;
    logic [2:0]  idx_q;

    logic [19:0] acc_adj;
    logic [35:0] step;
    logic [3:0]  digit;
    logic        blank;

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift {acc, bin} left by one.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        step = {acc_adj, bin_q} << 1;
    end

    // Converter next state. In IDLE, a new conversion starts whenever value differs from shadow.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cap_d    = cap_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (value != shadow_q) begin
                    bin_d   = value;
                    cap_d   = value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                acc_d = step[35:16];
                bin_d = step[15:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    bcd_d    = step[35:16];
                    shadow_d = cap_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Converter registers. A reset discards any partial conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            cap_q    <= '0;
            bin_q    <= '0;
            acc_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cap_q    <= cap_d;
            bin_q    <= bin_d;
            acc_q    <= acc_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Scan prescaler. The digit index advances once every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PreMax) begin
            pre_q <= '0;
            idx_q <= idx_q + 3'd1;
        end else begin
            pre_q <= pre_q + 16'd1;
        end
    end

    // Digit selection. In decimal mode, leading zeros are blanked, but digit 0 always shows.
    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        unique case (idx_q)
            3'd0: begin
                digit = dec_mode ? bcd_q[3:0] : shadow_q[3:0];
                blank = 1'b0;
            end
            3'd1: begin
                digit = dec_mode ? bcd_q[7:4] : shadow_q[7:4];
                blank = dec_mode && (bcd_q[19:4] == 16'd0);
            end
            3'd2: begin
                digit = dec_mode ? bcd_q[11:8] : shadow_q[11:8];
                blank = dec_mode && (bcd_q[19:8] == 12'd0);
            end
            3'd3: begin
                digit = dec_mode ? bcd_q[15:12] : shadow_q[15:12];
                blank = dec_mode && (bcd_q[19:12] == 8'd0);
            end
            3'd4: begin
                digit = bcd_q[19:16];
                blank = !dec_mode || (bcd_q[19:16] == 4'd0);
            end
            default: begin
                digit = 4'd0;
                blank = 1'b1;
            end
        endcase
    end

    // Registered anode and segment drive. A blank digit keeps its anode on and turns off all segments.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'd1 << idx_q);
            seg <= blank ? 8'hFF : encode(digit);
        end
    end

    assign busy = (state_q == StConv);

endmodule
